panda_sc_data_memory: RTL and testbench
=======================================

PANDA_SC_DATA_MEMORY -- requirements
Module: panda_sc_data_memory

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 1024, giving the number of 32-bit RAM words (power of two).
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'h8000_0000, giving the base byte address of the peripheral window.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port data_addr_i, input, 32 bits, the byte address from the load-store unit.
REQ-006 The block SHALL have port data_wdata_i, input, 32 bits, the lane-aligned store data.
REQ-007 The block SHALL have port data_we_i, input, 4 bits, the per-byte-lane write enable; lane i covers bits 8i+7:8i.
REQ-008 The block SHALL have port data_rdata_o, output, 32 bits, the word read data.
REQ-009 The block SHALL have port timer_irq_o, output, 1 bit, the machine timer interrupt.
REQ-010 The block SHALL have port halt_o, output, 1 bit, the sticky simulation-exit flag.
REQ-011 The block SHALL have port halt_code_o, output, 32 bits, the value written to TOHOST.

Function
REQ-012 Decode SHALL ignore data_addr_i[1:0]; RAM SHALL be selected when addr < RAM_WORDS*4, and MMIO when addr is in [MMIO_BASE, MMIO_BASE+0x14).
REQ-013 MMIO offsets SHALL be: 0x0 MTIME_LO, 0x4 MTIME_HI, 0x8 MTIMECMP_LO, 0xC MTIMECMP_HI, 0x10 TOHOST (write-only, reads 0).
REQ-014 Reads SHALL be combinational, with zero latency, to serve a single-cycle core; unmapped addresses SHALL read 32'h0.
REQ-015 Writes SHALL update only the enabled byte lanes of the selected word at the rising edge; unmapped writes SHALL be ignored.
REQ-016 A read of the address being written in the same cycle SHALL return the old value.
REQ-017 mtime (64 bits) SHALL increment by 1 every cycle, carrying from LO into HI, and SHALL wrap from all-ones to 0.
REQ-018 A write to MTIME_LO or MTIME_HI SHALL load the lane-merged value into mtime, and that cycle SHALL NOT increment mtime (the write wins).
REQ-019 timer_irq_o SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit, evaluated on the pre-edge values, giving 1 cycle of latency.
REQ-020 A TOHOST write with any data_we_i bit set SHALL set halt_o and latch halt_code_o (lane-merged over 0) at the next edge.
REQ-021 Once halt_o=1, both halt_o and halt_code_o SHALL hold until reset, and further TOHOST writes SHALL be ignored.
REQ-022 When data_we_i=4'b0000, there SHALL be no state change other than the mtime increment.

Reset
REQ-023 When rst_i=1 at an edge, mtime SHALL be set to 0, mtimecmp to 64'hFFFF_FFFF_FFFF_FFFF, timer_irq_o to 0, halt_o to 0, and halt_code_o to 0.
REQ-024 Reset SHALL take priority over a simultaneous write, including a write to TOHOST.
REQ-025 RAM contents SHALL NOT be reset; data_rdata_o SHALL remain combinational during reset.

Configuration
REQ-026 Macro PANDA_DATA_MEM_TIMER_EN SHALL gate the timer feature.
REQ-027 With PANDA_DATA_MEM_TIMER_EN defined, the block SHALL implement the mtime/mtimecmp registers and timer_irq_o per REQ-017 to REQ-019.
REQ-028 Without PANDA_DATA_MEM_TIMER_EN, offsets 0x0 to 0xC SHALL read 0, writes to them SHALL be ignored, timer_irq_o SHALL be tied to 0, and no timer flops SHALL exist.

Verification
REQ-029 Write word 32'h12345678 with we=4'hF at 0x4, then byte writes 8'hAB with we=4'b0100 at 0x5 -> reading 0x4 SHALL return 32'h12AB5678.
REQ-030 Halfword store we=4'b1100, wdata=32'h89AB0000 at 0x8 over 32'h0 -> reading 0x8 SHALL return 32'h89AB0000, and reading 0x9 SHALL return the same word.
REQ-031 Set MTIMECMP_HI=0 and MTIMECMP_LO=20 after reset -> timer_irq_o SHALL rise exactly one cycle after mtime reaches 20.
REQ-032 Write MTIME_LO=32'hFFFF_FFFF and MTIME_HI=0 -> after 1 cycle MTIME_HI SHALL read 1 and MTIME_LO SHALL read 0.
REQ-033 Write 32'h1 to TOHOST, then 32'h5 -> halt_o=1 and halt_code_o=1 SHALL hold; asserting rst_i in the same cycle as the write SHALL leave halt_o=0.

Source files
------------

// File: rtl/panda_sc_data_memory.sv
// Single-cycle data memory for the panda core: RAM, timer registers and a TOHOST halt latch.
// Define PANDA_DATA_MEM_TIMER_EN to build the mtime/mtimecmp timer; otherwise those offsets read 0.
module panda_sc_data_memory #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic        timer_irq_o,
  output logic        halt_o,
  output logic [31:0] halt_code_o
);
  localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                             input logic [3:0] we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  logic [31:0]      addr_w;
  logic [31:0]      mmio_off;
  logic             ram_sel;
  logic             mmio_sel;
  logic             wr_any;
  logic [IDX_W-1:0] ram_idx;

  // Byte offset inside the word is irrelevant for both decode and data.
  assign addr_w   = data_addr_i & 32'hFFFF_FFFC;
  assign mmio_off = addr_w - MMIO_BASE;
  assign ram_sel  = addr_w < RAM_BYTES;
  assign mmio_sel = !ram_sel && (addr_w >= MMIO_BASE) && (mmio_off < 32'h14);
  assign wr_any   = |data_we_i;
  assign ram_idx  = data_addr_i[IDX_W+1:2];

  // ---------------------------------------------------------------- RAM
  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] ram_rdata;

  assign ram_rdata = mem_q[ram_idx];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (ram_sel && data_we_i[i]) mem_q[ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
  end

  // ---------------------------------------------------------------- timer
  logic [31:0] timer_rdata;

`ifdef PANDA_DATA_MEM_TIMER_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    irq_d      = (mtime_q >= mtimecmp_q);
    // A software write to mtime replaces this cycle's increment.
    if (mmio_sel && wr_any) begin
      case (mmio_off[4:2])
        3'd0: mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], data_wdata_i, data_we_i)};
        3'd1: mtime_d = {lane_merge(mtime_q[63:32], data_wdata_i, data_we_i), mtime_q[31:0]};
        3'd2: mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], data_wdata_i, data_we_i);
        3'd3: mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], data_wdata_i, data_we_i);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    timer_rdata = 32'h0;
    case (mmio_off[4:2])
      3'd0: timer_rdata = mtime_q[31:0];
      3'd1: timer_rdata = mtime_q[63:32];
      3'd2: timer_rdata = mtimecmp_q[31:0];
      3'd3: timer_rdata = mtimecmp_q[63:32];
      default: ;
    endcase
  end

  assign timer_irq_o = irq_q;
`else
  assign timer_rdata = 32'h0;
  assign timer_irq_o = 1'b0;
`endif

  // ---------------------------------------------------------------- TOHOST
  logic        halt_q, halt_d;
  logic [31:0] halt_code_q, halt_code_d;

  always_comb begin
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    // First write wins; the exit code is frozen until reset.
    if (mmio_sel && (mmio_off[4:2] == 3'd4) && wr_any && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = lane_merge(32'h0, data_wdata_i, data_we_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
    end else begin
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign halt_o      = halt_q;
  assign halt_code_o = halt_code_q;

  // ---------------------------------------------------------------- read mux
  always_comb begin
    data_rdata_o = 32'h0;
    if (ram_sel)       data_rdata_o = ram_rdata;
    else if (mmio_sel) data_rdata_o = timer_rdata;
  end
endmodule

// File: tb/tb_panda_sc_data_memory.sv
// Scoreboard bench for panda_sc_data_memory: expected values are queued as stimulus is
// driven and popped when the combinational read or status output is sampled.
module tb_panda_sc_data_memory;
  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_rdata_o;
  logic        timer_irq_o, halt_o;
  logic [31:0] halt_code_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, e;

  panda_sc_data_memory dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_we_i(data_we_i), .data_rdata_o(data_rdata_o), .timer_irq_o(timer_irq_o),
    .halt_o(halt_o), .halt_code_o(halt_code_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    data_addr_i  = a;
    data_wdata_i = d;
    data_we_i    = we;
    tick();
    data_we_i    = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    data_addr_i = a;
    data_we_i   = 4'h0;
    #1;
    v = data_rdata_o;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic test_reset();
    logic [31:0] a [3];
    rst_i = 1'b1; data_addr_i = 0; data_wdata_i = 0; data_we_i = 0;
    tick(); tick();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if (32'(halt_o) !== e) begin n_err++; $display("FAIL reset_halt got=%h exp=%h", halt_o, e); end
    e = exp_q.pop_front(); n_chk++;
    if (halt_code_o !== e) begin n_err++; $display("FAIL reset_code got=%h exp=%h", halt_code_o, e); end
    e = exp_q.pop_front(); n_chk++;
    if (32'(timer_irq_o) !== e) begin n_err++; $display("FAIL reset_irq got=%h exp=%h", timer_irq_o, e); end
    rst_i = 1'b0;
    a = '{MB, MB + 8, MB + 12};
`ifdef PANDA_DATA_MEM_TIMER_EN
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFF);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      rd(a[i], got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL reset_mmio[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_ram_lanes();
    logic [31:0] a [4];
    wr(32'h4, 32'h1234_5678, 4'hF);
    wr(32'h5, 32'h00AB_0000, 4'b0100);
    wr(32'h8, 32'h0, 4'hF);
    wr(32'h8, 32'h89AB_0000, 4'b1100);
    a = '{32'h4, 32'h8, 32'h9, 32'hB};
    exp_q.push_back(32'h12AB_5678); exp_q.push_back(32'h89AB_0000);
    exp_q.push_back(32'h89AB_0000); exp_q.push_back(32'h89AB_0000);
    for (int i = 0; i < 4; i++) begin
      rd(a[i], got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL ram_lanes[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_ram_random();
    logic [31:0] model [8];
    logic [31:0] d;
    logic [3:0]  we;
    int          w;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      wr(32'h40 + 32'(4 * i), model[i], 4'hF);
    end
    for (int i = 0; i < 16; i++) begin
      w = $urandom_range(0, 7);
      d = $urandom;
      we = 4'($urandom_range(0, 15));
      model[w] = merge(model[w], d, we);
      wr(32'h40 + 32'(4 * w) + 32'($urandom_range(0, 3)), d, we);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < 8; i++) begin
      rd(32'h40 + 32'(4 * i), got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL ram_rand[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_read_during_write();
    exp_q.push_back(32'h12AB_5678);
    exp_q.push_back(32'hDEAD_BEEF);
    data_addr_i = 32'h4; data_wdata_i = 32'hDEAD_BEEF; data_we_i = 4'hF;
    #1;
    got = data_rdata_o;
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rdw_old got=%h exp=%h", got, e); end
    tick();
    rd(32'h4, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rdw_new got=%h exp=%h", got, e); end
  endtask

  task automatic test_unmapped();
    logic [31:0] a [6];
    wr(32'h0000_1004, 32'hFFFF_FFFF, 4'hF);
    wr(MB + 32'h14, 32'hFFFF_FFFF, 4'hF);
    wr(32'h4, 32'h0, 4'h0);
    a = '{32'h0000_1004, 32'h4, MB + 32'h14, 32'h4000_0000, MB + 32'h10, MB - 32'h4};
    exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      rd(a[i], got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL unmapped[%0d] got=%h exp=%h", i, got, e); end
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if (32'(halt_o) !== e) begin n_err++; $display("FAIL unmapped_halt got=%h exp=%h", halt_o, e); end
  endtask

`ifdef PANDA_DATA_MEM_TIMER_EN
  task automatic test_timer();
    logic [31:0] exp_mt;
    logic [31:0] a [5];
    logic [31:0] ev [5];
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    wr(MB + 32'hC, 32'h0, 4'hF);
    wr(MB + 32'h8, 32'd20, 4'hF);
    exp_mt = 32'd2;
    for (int k = 0; k < 24; k++) begin
      exp_q.push_back(exp_mt);
      exp_q.push_back(32'(exp_mt >= 32'd21));
      rd(MB, got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL mtime_count got=%h exp=%h", got, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(timer_irq_o) !== e)
        begin n_err++; $display("FAIL irq_rise mtime=%0d got=%h exp=%h", exp_mt, timer_irq_o, e); end
      tick();
      exp_mt++;
    end
    // carry from LO into HI
    wr(MB, 32'hFFFF_FFFF, 4'hF);
    wr(MB + 32'h4, 32'h0, 4'hF);
    a  = '{MB, MB + 4, MB + 8, MB + 12, MB + 16};
    ev = '{32'hFFFF_FFFF, 32'h0, 32'd20, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) exp_q.push_back(ev[i]);
    for (int i = 0; i < 5; i++) begin
      rd(a[i], got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL mtime_load[%0d] got=%h exp=%h", i, got, e); end
    end
    tick();
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    rd(MB + 4, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL carry_hi got=%h exp=%h", got, e); end
    rd(MB, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL carry_lo got=%h exp=%h", got, e); end
    // full wrap, and irq following the wrapped value one cycle late
    wr(MB, 32'hFFFF_FFFF, 4'hF);
    wr(MB + 4, 32'hFFFF_FFFF, 4'hF);
    tick();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    rd(MB, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL wrap_lo got=%h exp=%h", got, e); end
    rd(MB + 4, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL wrap_hi got=%h exp=%h", got, e); end
    e = exp_q.pop_front(); n_chk++;
    if (32'(timer_irq_o) !== e) begin n_err++; $display("FAIL wrap_irq1 got=%h exp=%h", timer_irq_o, e); end
    tick();
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if (32'(timer_irq_o) !== e) begin n_err++; $display("FAIL wrap_irq0 got=%h exp=%h", timer_irq_o, e); end
  endtask
`else
  task automatic test_timer();
    wr(MB, 32'h1234, 4'hF);
    wr(MB + 8, 32'h0, 4'hF);
    wr(MB + 12, 32'h0, 4'hF);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      rd(MB + 32'(4 * i), got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL notimer_rd[%0d] got=%h exp=%h", i, got, e); end
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if (32'(timer_irq_o) !== e) begin n_err++; $display("FAIL notimer_irq got=%h exp=%h", timer_irq_o, e); end
  endtask
`endif

  task automatic test_halt();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    wr(MB + 32'h10, 32'h1, 4'hF);
    wr(MB + 32'h10, 32'h5, 4'hF);
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if (32'(halt_o) !== e) begin n_err++; $display("FAIL halt_set got=%h exp=%h", halt_o, e); end
    e = exp_q.pop_front(); n_chk++;
    if (halt_code_o !== e) begin n_err++; $display("FAIL halt_code_sticky got=%h exp=%h", halt_code_o, e); end
    rd(MB + 32'h10, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL tohost_rd got=%h exp=%h", got, e); end
    // reset beats a simultaneous TOHOST write
    rst_i = 1'b1;
    wr(MB + 32'h10, 32'h7, 4'hF);
    rst_i = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF);
    e = exp_q.pop_front(); n_chk++;
    if (32'(halt_o) !== e) begin n_err++; $display("FAIL halt_rst_prio got=%h exp=%h", halt_o, e); end
    e = exp_q.pop_front(); n_chk++;
    if (halt_code_o !== e) begin n_err++; $display("FAIL code_rst_prio got=%h exp=%h", halt_code_o, e); end
    rd(32'h4, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL ram_kept got=%h exp=%h", got, e); end
    // lane-merged over zero
    wr(MB + 32'h10, 32'hAABB_CCDD, 4'b0010);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0000_CC00);
    e = exp_q.pop_front(); n_chk++;
    if (32'(halt_o) !== e) begin n_err++; $display("FAIL halt_lane got=%h exp=%h", halt_o, e); end
    e = exp_q.pop_front(); n_chk++;
    if (halt_code_o !== e) begin n_err++; $display("FAIL code_lane got=%h exp=%h", halt_code_o, e); end
  endtask

  initial begin
    test_reset();
    test_ram_lanes();
    test_ram_random();
    test_read_during_write();
    test_unmapped();
    test_timer();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
